// File: rtl/subservient_wb_sram_bridge.sv
// Wishbone classic slave that serialises 32-bit word accesses into byte accesses on an 8-bit SRAM.
// Writes ack 5 cycles after stb is sampled and reads ack after 6. Only one access is in flight at a time.
module subservient_wb_sram_bridge #(
    parameter int depth = 1024,
    parameter int aw    = $clog2(depth)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [aw-3:0] i_wb_adr,
    input  logic [31:0]   i_wb_dat,
    input  logic [3:0]    i_wb_sel,
    input  logic          i_wb_we,
    input  logic          i_wb_stb,
    output logic [31:0]   o_wb_rdt,
    output logic          o_wb_ack,
    output logic [aw-1:0] o_sram_waddr,
    output logic [7:0]    o_sram_wdata,
    output logic          o_sram_wen,
    output logic [aw-1:0] o_sram_raddr,
    output logic          o_sram_ren,
    input  logic [7:0]    i_sram_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        RWAIT = 3'd3,
        ACK   = 3'd4
    } state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic        ren_q;
    logic [31:0] rdt;

    // The lane counter supplies the low address bits and cannot carry into the word address.
    assign o_sram_waddr = {i_wb_adr, cnt};
    assign o_sram_raddr = {i_wb_adr, cnt};
    assign o_sram_wdata = i_wb_dat[{cnt, 3'b000} +: 8];

    assign o_sram_wen = (state == WRITE) & i_wb_sel[cnt];
    assign o_sram_ren = (state == READ);
    assign o_wb_ack   = (state == ACK);
    assign o_wb_rdt   = rdt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            ren_q <= 1'b0;
            rdt   <= 32'd0;
        end else begin
            ren_q <= o_sram_ren;
            // SRAM data lags the read enable by one cycle, so bytes shift in LSB-lane first.
            if (ren_q)
                rdt <= {i_sram_rdata, rdt[31:8]};

            case (state)
                IDLE: begin
                    cnt <= 2'd0;
                    if (i_wb_stb)
                        state <= i_wb_we ? WRITE : READ;
                end
                WRITE: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3)
                        state <= ACK;
                end
                READ: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3)
                        state <= RWAIT;
                end
                RWAIT: state <= ACK;
                ACK:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
